// File: rtl/video_timing_analyzer.sv
// rtl/video_timing_analyzer.sv - measures HSYNC/VSYNC/DE geometry of incoming video and flags a stable lock
module video_timing_analyzer #(
    parameter int LOCK_FRAMES  = 3,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic        HSYNC_in,
    input  logic        VSYNC_in,
    input  logic        DE_in,
    output logic [10:0] h_total,
    output logic [10:0] h_synclen,
    output logic [10:0] h_active,
    output logic [10:0] v_total,
    output logic [10:0] v_synclen,
    output logic [10:0] v_active,
    output logic        locked,
    output logic        frame_start
);

    typedef enum logic [1:0] {NOSYNC, ACQUIRE, LOCKED} state_t;

    typedef struct packed {
        logic [10:0] ht;
        logic [10:0] hs;
        logic [10:0] ha;
        logic [10:0] vt;
        logic [10:0] vs;
        logic [10:0] va;
    } geom_t;

    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);
    localparam logic [12:0] TO_N   = 13'(TIMEOUT_CLKS);
    localparam logic [10:0] MAX11  = 11'h7ff;

    state_t      state;
    logic        hs_r, vs_r, de_r, hs_d, vs_at_hs;
    logic [12:0] h_cnt;
    logic [10:0] hs_cnt, hs_len, de_cnt;
    logic [10:0] v_cnt, vs_cnt, act_cnt, h_act;
    logic [7:0]  stable_cnt;
    logic        have_prev;
    geom_t       prev, out_q, cand;

    logic hs_edge, hs_trail, vs_edge, timeout, line_active, match;
    logic [10:0] act_now, hact_now;

    function automatic logic [10:0] sat11(input logic [13:0] x);
        return (x > 14'd2047) ? MAX11 : x[10:0];
    endfunction

    assign hs_edge     = hs_d & ~hs_r;
    assign hs_trail    = ~hs_d & hs_r;
    // Frame boundary: VSYNC low at this line start but high at the previous one
    assign vs_edge     = hs_edge & ~vs_r & vs_at_hs;
    assign timeout     = (h_cnt >= TO_N);
    assign line_active = (de_cnt != 11'd0);
    assign act_now     = line_active ? sat11({3'b0, act_cnt} + 14'd1) : act_cnt;
    assign hact_now    = (h_act == 11'd0 && line_active) ? de_cnt : h_act;

    always_comb begin
        cand    = '0;
        cand.ht = sat11({1'b0, h_cnt} + 14'd1);
        cand.hs = hs_len;
        cand.ha = hact_now;
        cand.vt = sat11({3'b0, v_cnt} + 14'd1);
        cand.vs = vs_cnt;
        cand.va = act_now;
    end

    assign match = have_prev && (cand == prev);

    assign h_total   = out_q.ht;
    assign h_synclen = out_q.hs;
    assign h_active  = out_q.ha;
    assign v_total   = out_q.vt;
    assign v_synclen = out_q.vs;
    assign v_active  = out_q.va;

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= NOSYNC;
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            de_r        <= 1'b0;
            hs_d        <= 1'b1;
            vs_at_hs    <= 1'b0;
            h_cnt       <= '0;
            hs_cnt      <= '0;
            hs_len      <= '0;
            de_cnt      <= '0;
            v_cnt       <= '0;
            vs_cnt      <= '0;
            act_cnt     <= '0;
            h_act       <= '0;
            stable_cnt  <= '0;
            have_prev   <= 1'b0;
            prev        <= '0;
            out_q       <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs_r        <= HSYNC_in;
            vs_r        <= VSYNC_in;
            de_r        <= DE_in;
            hs_d        <= hs_r;
            frame_start <= 1'b0;
            if (timeout) begin
                state      <= NOSYNC;
                h_cnt      <= '0;
                hs_cnt     <= '0;
                hs_len     <= '0;
                de_cnt     <= '0;
                v_cnt      <= '0;
                vs_cnt     <= '0;
                act_cnt    <= '0;
                h_act      <= '0;
                stable_cnt <= '0;
                have_prev  <= 1'b0;
                out_q      <= '0;
                locked     <= 1'b0;
            end else begin
                if (hs_edge)
                    h_cnt <= '0;
                else if (h_cnt != 13'h1fff)
                    h_cnt <= h_cnt + 13'd1;

                if (hs_edge)
                    hs_cnt <= 11'd1;
                else if (!hs_r && hs_cnt != MAX11)
                    hs_cnt <= hs_cnt + 11'd1;
                if (hs_trail)
                    hs_len <= hs_cnt;

                if (hs_edge)
                    de_cnt <= {10'b0, de_r};
                else if (de_r && de_cnt != MAX11)
                    de_cnt <= de_cnt + 11'd1;

                if (hs_edge) begin
                    vs_at_hs <= vs_r;
                    if (vs_edge) begin
                        v_cnt       <= '0;
                        vs_cnt      <= 11'd1;
                        act_cnt     <= '0;
                        h_act       <= '0;
                        frame_start <= 1'b1;
                        case (state)
                            NOSYNC: begin
                                state      <= ACQUIRE;
                                have_prev  <= 1'b0;
                                stable_cnt <= '0;
                            end
                            ACQUIRE: begin
                                prev      <= cand;
                                have_prev <= 1'b1;
                                out_q     <= cand;
                                if (match) begin
                                    stable_cnt <= stable_cnt + 8'd1;
                                    if (stable_cnt + 8'd1 >= LOCK_N) begin
                                        state  <= LOCKED;
                                        locked <= 1'b1;
                                    end
                                end else begin
                                    stable_cnt <= '0;
                                    locked     <= 1'b0;
                                end
                            end
                            default: begin
                                prev  <= cand;
                                out_q <= cand;
                                if (!match) begin
                                    state      <= ACQUIRE;
                                    stable_cnt <= '0;
                                    locked     <= 1'b0;
                                end
                            end
                        endcase
                    end else begin
                        v_cnt   <= sat11({3'b0, v_cnt} + 14'd1);
                        if (!vs_r)
                            vs_cnt <= sat11({3'b0, vs_cnt} + 14'd1);
                        act_cnt <= act_now;
                        h_act   <= hact_now;
                    end
                end
            end
        end
    end

endmodule
